// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared state encoding and default widths for the memory arbiter
package mips_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Bus owner encoding; the arbiter drives grant straight from this value.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mips_arb_starve.sv
// rtl/mips_arb_starve.sv - data-first priority decision with bounded fetch starvation
module mips_arb_starve
  import mips_bus_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       arbitrate,
  output arb_state_t next_owner
);

  localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  // Data wins until it has taken MAX_C grants in a row past a waiting fetch.
  always_comb begin
    next_owner = IDLE;
    if (d_req && (starve_cnt < MAX_C)) begin
      next_owner = GNT_D;
    end else if (i_req) begin
      next_owner = GNT_I;
    end else if (d_req) begin
      next_owner = GNT_D;
    end
  end

  // Count data grants that passed over a waiting fetch; any other grant resets the run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (arbitrate) begin
      case (next_owner)
        GNT_D: begin
          if (!i_req) begin
            starve_cnt <= 4'd0;
          end else if (starve_cnt < MAX_C) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        GNT_I:   starve_cnt <= 4'd0;
        default: starve_cnt <= starve_cnt;
      endcase
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - shares one memory bus between the fetch and data ports
module mips_mem_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_waitrequest,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_waitrequest,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_waitrequest,
  output logic [1:0]          grant
);

  arb_state_t state;
  arb_state_t state_next;
  arb_state_t next_owner;
  logic       i_req;
  logic       d_req;
  logic       arbitrate;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Decide in IDLE, or on the edge where the current owner's transfer completes.
  assign arbitrate = (state == IDLE) | ~m_waitrequest;

  mips_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .d_req     (d_req),
    .arbitrate (arbitrate),
    .next_owner(next_owner)
  );

  // Owner register; reset drops the bus immediately, abandoning any transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Hold the owner until its transfer completes, then hand over without a bubble.
  always_comb begin
    state_next = state;
    if (arbitrate) begin
      state_next = next_owner;
    end
  end

  // Route the owner onto the bus; a simultaneous read+write is forwarded as a write.
  always_comb begin
    m_address    = '0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_byteenable = '1;
    m_writedata  = d_writedata;
    case (state)
      GNT_I: begin
        m_address = i_address;
        m_read    = i_read;
      end
      GNT_D: begin
        m_address    = d_address;
        m_read       = d_read & ~d_write;
        m_write      = d_write;
        m_byteenable = d_byteenable;
      end
      default: ;
    endcase
  end

  assign i_waitrequest = i_req & ~((state == GNT_I) & ~m_waitrequest);
  assign d_waitrequest = d_req & ~((state == GNT_D) & ~m_waitrequest);
  assign i_readdata    = m_readdata;
  assign d_readdata    = m_readdata;
  assign grant         = state;

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Two-requester arbiter that shares one external memory bus between the CPU instruction-fetch port and the data port. This lets the Harvard core run against a single unified memory with wait states.
- Sits between mips_cpu_harvard (fetch and data ports) and the memory/bus interconnect.
- Fixed priority to data, with a bounded anti-starvation rule for fetch.
- Exactly one transaction is in flight on the bus at a time.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_MAX, 4, number of consecutive data grants allowed while fetch waits; range 1..15.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_address  in  ADDR_W  fetch address.
- i_read  in  1  fetch request.
- i_readdata  out  DATA_W  fetch read data.
- i_waitrequest  out  1  fetch stall.
- d_address  in  ADDR_W  data address.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_byteenable  in  DATA_W/8  data byte lanes.
- d_writedata  in  DATA_W  data write data.
- d_readdata  out  DATA_W  data read data.
- d_waitrequest  out  1  data stall.
- m_address  out  ADDR_W  bus address.
- m_read  out  1  bus read strobe.
- m_write  out  1  bus write strobe.
- m_byteenable  out  DATA_W/8  bus byte lanes.
- m_writedata  out  DATA_W  bus write data.
- m_readdata  in  DATA_W  bus read data, valid in the cycle m_waitrequest is low.
- m_waitrequest  in  1  bus stall.
- grant  out  2  current owner: 00 none, 01 fetch, 10 data.

Behaviour:
- Requests:
  - i_req = i_read.
  - d_req = d_read | d_write.
  - A requester holds its request and all of its inputs stable until its waitrequest is sampled low.
  - d_read & d_write together is illegal. The arbiter forwards it as a write, with m_read = 0.
- FSM states: IDLE, GNT_I, GNT_D. State is registered; the grant output equals the state encoding.
- Reset (asynchronous, reset = 0):
  - State goes to IDLE and starve_cnt goes to 0, immediately and without a clock edge.
  - m_read = 0, m_write = 0, grant = 00.
  - Any in-flight bus transaction is abandoned. Both waitrequests show the request-pending value defined below.
- Arbitration function (evaluated in IDLE, and at the completion edge of GNT_*):
  - If d_req and starve_cnt < STARVE_MAX, grant data.
  - Otherwise, if i_req, grant fetch.
  - Otherwise, if d_req, grant data.
  - Otherwise, go to IDLE.
- IDLE: arbitrate at every edge. The first grant is visible on the bus the cycle after the request is first seen (1 cycle latency from IDLE).
- GNT_x datapath muxing (combinational):
  - m_address and m_read/m_write are driven from the owner only; the non-owner's strobes are masked.
  - In GNT_I: m_byteenable = all ones, m_write = 0, m_writedata is don't-care.
- Completion: at the edge where the state is GNT_x and m_waitrequest = 0.
  - The owner's transaction is complete.
  - Arbitrate directly at that edge. There is no idle bubble when another request is pending.
  - A requester that just completed and immediately re-requests competes normally.
- Waitrequest outputs:
  - i_waitrequest = i_req & ~(state == GNT_I & ~m_waitrequest). d_waitrequest is defined likewise.
  - Both are 0 when the requester is idle.
- Read data: m_readdata is forwarded combinationally to both i_readdata and d_readdata. It is meaningful only to the owner, in its completion cycle.
- Starvation counter starve_cnt (4 bits, saturating at STARVE_MAX):
  - On each data grant made while i_req = 1: increment.
  - On a data grant made while i_req = 0: clear.
  - On a fetch grant: clear.
- clk runs continuously. There is no enable; the CPU-side clk_enable is not routed here.

Decomposition:
- Shared package mips_bus_pkg:
  - typedef enum of the state encoding (IDLE = 2'b00, GNT_I = 2'b01, GNT_D = 2'b10), reused by grant.
  - Default bus widths.
- One sub-module, mips_arb_starve, holding starve_cnt and the priority decision (inputs i_req, d_req, arbitrate strobe; output next owner).
- Datapath muxing stays in the top module.

Test Plan:
- Fetch only, memory 0 wait states: i_read = 1, i_address = 0xBFC00000, m_readdata = 0x24020005.
  - grant = 01 in cycle 1; i_waitrequest low in cycle 1; i_readdata = 0x24020005; m_write = 0.
- Both request in the same cycle, STARVE_MAX = 4, 2 wait states per access:
  - d_write to 0x1000 with 0xDEADBEEF, byteenable 0xF, is served first (grant = 10 for 3 cycles).
  - Fetch is granted at the completion edge with no idle cycle.
- Starvation: d_req held continuously with back-to-back transactions, i_req held.
  - Exactly 4 data grants occur, then 1 fetch grant, then data resumes.
  - starve_cnt reads 0 after the fetch grant.
- Asynchronous reset mid-transaction: assert reset = 0 during GNT_D with m_waitrequest = 1, off a clock edge.
  - m_write falls to 0 and grant falls to 00 within the same cycle.
  - After release, the pending request is re-granted from IDLE.
- Illegal d_read & d_write together: m_write = 1, m_read = 0, data forwarded unchanged.
- Byte write: d_byteenable = 0x3 on a write.
  - m_byteenable = 0x3.
  - A subsequent fetch shows m_byteenable = 0xF.
